// File: rtl/sequence_controller.sv
// ============================================================================
// sequence_controller
// ----------------------------------------------------------------------------
// Eight-phase instruction sequencer for the RISC CPU core. Every instruction
// walks through INST_ADDR .. STORE (one phase per clock). The control strobes
// are Moore decodes of the phase, the latched opcode and the ALU zero flag.
// This block is the only source of the address mux select.
//
// Parameters:
//   HALT_STICKY   1: HLT parks the sequencer in HALTED until rst.
//                 0: halt pulses during phase 4 and sequencing continues.
//
// Optional feature (macro SEQ_SINGLE_STEP_EN):
//   Adds input step and output waiting. STORE -> INST_ADDR only on a cycle
//   with step=1; otherwise the sequencer holds in phase 7 with waiting=1.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   opcode   in   [2:0] opcode from IR (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4
//                 LDA=5 STO=6 JMP=7)
//   zero     in   accumulator-is-zero flag
//   step     in   single-step advance (SEQ_SINGLE_STEP_EN only)
//   sel      out  address mux select (1: PC, 0: IR operand)
//   rd       out  memory read enable
//   wr       out  memory write enable
//   ld_ir    out  instruction register load
//   ld_ac    out  accumulator load
//   inc_pc   out  program counter increment
//   ld_pc    out  program counter load (jump)
//   data_e   out  accumulator-to-data-bus tristate enable
//   halt     out  processor halted indication
//   phase    out  [2:0] current phase (debug/trace)
//   waiting  out  held in phase 7 awaiting step (SEQ_SINGLE_STEP_EN only)
// ============================================================================
module sequence_controller #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
    output logic       waiting,
`endif
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam int unsigned STATE_W = 4;

    // Phases 0-7 map directly onto their encodings; HALTED sits outside them.
    localparam logic [STATE_W-1:0] INST_ADDR  = 4'd0;
    localparam logic [STATE_W-1:0] INST_FETCH = 4'd1;
    localparam logic [STATE_W-1:0] INST_LOAD  = 4'd2;
    localparam logic [STATE_W-1:0] IDLE       = 4'd3;
    localparam logic [STATE_W-1:0] OP_ADDR    = 4'd4;
    localparam logic [STATE_W-1:0] OP_FETCH   = 4'd5;
    localparam logic [STATE_W-1:0] ALU_OP     = 4'd6;
    localparam logic [STATE_W-1:0] STORE      = 4'd7;
    localparam logic [STATE_W-1:0] HALTED     = 4'd8;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               aluop;
    logic               hold_q;     // already spent at least one cycle in STORE
    logic               hold_next;

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INST_ADDR;
            hold_q <= 1'b0;
        end else begin
            state  <= state_next;
            hold_q <= hold_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = INST_ADDR;
        hold_next  = 1'b0;
        case (state)
            INST_ADDR:  state_next = INST_FETCH;
            INST_FETCH: state_next = INST_LOAD;
            INST_LOAD:  state_next = IDLE;
            IDLE:       state_next = OP_ADDR;
            OP_ADDR: begin
                if (HALT_STICKY && (opcode == OP_HLT)) begin
                    state_next = HALTED;
                end else begin
                    state_next = OP_FETCH;
                end
            end
            OP_FETCH:   state_next = ALU_OP;
            ALU_OP:     state_next = STORE;
            STORE: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (step) begin
                    state_next = INST_ADDR;
                end else begin
                    state_next = STORE;
                    hold_next  = 1'b1;
                end
`else
                state_next = INST_ADDR;
`endif
            end
            HALTED: begin
                // Only reachable when sticky; falls back to fetch otherwise.
                state_next = HALT_STICKY ? HALTED : INST_ADDR;
            end
            default:    state_next = INST_ADDR;
        endcase
    end

    // Moore output decode; illegal encodings drive everything low.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        phase  = 3'd0;
`ifdef SEQ_SINGLE_STEP_EN
        waiting = 1'b0;
`endif
        case (state)
            INST_ADDR: begin
                phase = 3'd0;
                sel   = 1'b1;
            end
            INST_FETCH: begin
                phase = 3'd1;
                sel   = 1'b1;
                rd    = 1'b1;
            end
            INST_LOAD, IDLE: begin
                phase = 3'(state);
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                phase  = 3'd4;
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            OP_FETCH: begin
                phase = 3'd5;
                rd    = aluop;
            end
            ALU_OP: begin
                phase  = 3'd6;
                rd     = aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            STORE: begin
                phase = 3'd7;
                if (hold_q) begin
                    // Stalled waiting for step: only the waiting flag is live.
`ifdef SEQ_SINGLE_STEP_EN
                    waiting = 1'b1;
`endif
                end else begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
            end
            HALTED: begin
                phase = 3'd4;
                halt  = 1'b1;
            end
            default: begin
                phase = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_controller.sv
// ============================================================================
// tb_sequence_controller
// ----------------------------------------------------------------------------
// Drives a sticky-halt and a pulse-halt sequencer from the same inputs and
// compares every output each cycle against a phase-counter reference model.
// Define SEQ_SINGLE_STEP_EN for both files to exercise the step/waiting ports.
// ============================================================================
module tb_sequence_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       step;

    always #5 clk = ~clk;

    // Index 0: HALT_STICKY=1, index 1: HALT_STICKY=0.
    logic       sel_o    [2];
    logic       rd_o     [2];
    logic       wr_o     [2];
    logic       ld_ir_o  [2];
    logic       ld_ac_o  [2];
    logic       inc_pc_o [2];
    logic       ld_pc_o  [2];
    logic       data_e_o [2];
    logic       halt_o   [2];
    logic [2:0] phase_o  [2];
    logic       waiting_o[2];

    sequence_controller #(.HALT_STICKY(1'b1)) dut_sticky (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef SEQ_SINGLE_STEP_EN
        .step   (step),
        .waiting(waiting_o[0]),
`endif
        .sel    (sel_o[0]),
        .rd     (rd_o[0]),
        .wr     (wr_o[0]),
        .ld_ir  (ld_ir_o[0]),
        .ld_ac  (ld_ac_o[0]),
        .inc_pc (inc_pc_o[0]),
        .ld_pc  (ld_pc_o[0]),
        .data_e (data_e_o[0]),
        .halt   (halt_o[0]),
        .phase  (phase_o[0])
    );

    sequence_controller #(.HALT_STICKY(1'b0)) dut_pulse (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef SEQ_SINGLE_STEP_EN
        .step   (step),
        .waiting(waiting_o[1]),
`endif
        .sel    (sel_o[1]),
        .rd     (rd_o[1]),
        .wr     (wr_o[1]),
        .ld_ir  (ld_ir_o[1]),
        .ld_ac  (ld_ac_o[1]),
        .inc_pc (inc_pc_o[1]),
        .ld_pc  (ld_pc_o[1]),
        .data_e (data_e_o[1]),
        .halt   (halt_o[1]),
        .phase  (phase_o[1])
    );

`ifndef SEQ_SINGLE_STEP_EN
    assign waiting_o[0] = 1'b0;
    assign waiting_o[1] = 1'b0;
`endif

    // Reference model: phase number plus halted / stalled flags per DUT.
    int m_phase[2];
    bit m_halted[2];
    bit m_stalled[2];

    int n_checks = 0;
    int n_fails  = 0;

    // Expected vector {waiting,sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt,phase}.
    function automatic logic [12:0] expected(input int k);
        logic       w, s, r, wrx, li, la, ip, lp, de, h;
        logic [2:0] ph;
        bit         alu;
        int         p;
        alu = (opcode >= 3'd2) && (opcode <= 3'd5);
        p   = m_phase[k];
        {w, s, r, wrx, li, la, ip, lp, de, h} = '0;
        ph  = 3'(p);
        if (m_halted[k]) begin
            h  = 1'b1;
            ph = 3'd4;
        end else if (m_stalled[k]) begin
            w = 1'b1;
        end else begin
            s   = (p <= 3);
            r   = (p >= 1 && p <= 3) || (p >= 5 && alu);
            li  = (p == 2 || p == 3);
            ip  = (p == 4) || (p == 6 && opcode == 3'd1 && zero);
            h   = (p == 4 && opcode == 3'd0);
            lp  = (p >= 6 && opcode == 3'd7);
            de  = (p >= 6 && opcode == 3'd6);
            wrx = (p == 7 && opcode == 3'd6);
            la  = (p == 7 && alu);
        end
        return {w, s, r, wrx, li, la, ip, lp, de, h, ph};
    endfunction

    function automatic logic [12:0] actual(input int k);
        return {waiting_o[k], sel_o[k], rd_o[k], wr_o[k], ld_ir_o[k], ld_ac_o[k],
                inc_pc_o[k], ld_pc_o[k], data_e_o[k], halt_o[k], phase_o[k]};
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] = 0; m_halted[k] = 0; m_stalled[k] = 0;
            end else if (m_halted[k]) begin
                m_halted[k] = 1;
            end else if (m_phase[k] == 7) begin
`ifdef SEQ_SINGLE_STEP_EN
                if (step) begin
                    m_phase[k] = 0; m_stalled[k] = 0;
                end else begin
                    m_stalled[k] = 1;
                end
`else
                m_phase[k] = 0;
`endif
            end else if (m_phase[k] == 4 && opcode == 3'd0 && k == 0) begin
                m_halted[k] = 1;
            end else begin
                m_phase[k] = m_phase[k] + 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [12:0] a, e;
        for (int k = 0; k < 2; k++) begin
            a = actual(k);
            e = expected(k);
            n_checks++;
            assert (a === e) else begin
                n_fails++;
                $error("FAIL %s dut%0d model_phase=%0d observed=%b expected=%b",
                       tag, k, m_phase[k], a, e);
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, check, then take the edge.
    task automatic cyc(input string tag, input logic [2:0] op, input logic z,
                       input logic r, input logic s);
        @(negedge clk);
        opcode = op;
        zero   = z;
        rst    = r;
        step   = s;
        #1;
        check(tag);
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        rst = 1'b1; opcode = 3'd2; zero = 1'b0; step = 1'b1;
        @(posedge clk);
        model_edge();

        for (int i = 0; i < 16; i++) cyc("add_run", 3'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8;  i++) cyc("skz_z1",  3'd1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8;  i++) cyc("skz_z0",  3'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8;  i++) cyc("sto",     3'd6, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8;  i++) cyc("jmp",     3'd7, 1'b1, 1'b0, 1'b1);
        // Opcode noise in fetch phases must not matter.
        for (int i = 0; i < 4;  i++) cyc("fetch_noise", 3'(i * 2 + 1), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4;  i++) cyc("and_tail", 3'd3, 1'b1, 1'b0, 1'b1);

        // HLT: sticky DUT parks, pulse DUT keeps sequencing.
        for (int i = 0; i < 28; i++) cyc("hlt", 3'd0, 1'(i & 1), 1'b0, 1'b1);
        cyc("hlt_rst", 3'd0, 1'b0, 1'b1, 1'b1);
        cyc("after_hlt_rst", 3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc("xor_realign", 3'd4, 1'b0, 1'b0, 1'b1);

        // Reset in phase 6 of a store.
        for (int i = 0; i < 6; i++) cyc("sto_pre_rst", 3'd6, 1'b0, 1'b0, 1'b1);
        cyc("sto_rst_p6", 3'd6, 1'b0, 1'b1, 1'b1);
        cyc("sto_after_rst", 3'd6, 1'b0, 1'b0, 1'b1);

`ifdef SEQ_SINGLE_STEP_EN
        // Finish the store, then stall in phase 7 without step.
        for (int i = 0; i < 6;  i++) cyc("step_pre", 3'd6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc("step_hold", 3'd6, 1'b0, 1'b0, 1'b0);
        cyc("step_go", 3'd6, 1'b0, 1'b0, 1'b1);
        cyc("step_p0", 3'd6, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc("random", 3'($urandom_range(7)), 1'($urandom_range(1)),
                1'($urandom_range(59) == 0), 1'($urandom_range(2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
- Eight-phase instruction sequencer for the RISC CPU core.
- Each instruction takes 8 clocks. The controller drives the address mux select, memory read/write strobes, and the IR, PC and accumulator load/increment enables, based on the latched opcode and the ALU zero flag.
- Sits between the instruction register and the datapath. It is the only source of the address mux select.

Parameters:
HALT_STICKY, 1, 1: HLT parks the controller in a HALTED state until reset. 0: halt pulses for one cycle and sequencing continues.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
opcode  input  3  opcode field from instruction register (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7)
zero  input  1  accumulator-is-zero flag from ALU
sel  output  1  address mux select (1: PC address, 0: IR operand address)
rd  output  1  memory read enable
wr  output  1  memory write enable
ld_ir  output  1  instruction register load
ld_ac  output  1  accumulator load
inc_pc  output  1  program counter increment
ld_pc  output  1  program counter load (jump)
data_e  output  1  accumulator-to-data-bus tristate enable
halt  output  1  processor halted indication
phase  output  3  current phase, 0-7 (debug/trace)

Behaviour:
- One clock; reset is synchronous and active-high. On a rising edge with rst=1, state goes to INST_ADDR (phase=0), whatever the current state, including mid-instruction and HALTED.
- After the reset edge: sel=1 and all other control outputs 0.
- State register: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR. One transition per clock.
- Extra state HALTED exists only when HALT_STICKY=1. It is encoded outside 0-7 internally; phase reports 4 while in it.
- Outputs are Moore-style combinational decodes of state, opcode and zero. No output register; outputs are valid in the same cycle as the state.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Per-phase outputs (unlisted outputs = 0):
  - 0: sel=1
  - 1: sel=1, rd=1
  - 2: sel=1, rd=1, ld_ir=1
  - 3: sel=1, rd=1, ld_ir=1
  - 4: inc_pc=1; halt=(opcode==HLT)
  - 5: rd=ALUOP
  - 6: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO)
  - 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO)
- HLT handling:
  - HALT_STICKY=1: in phase 4 with opcode==HLT, the next state is HALTED.
  - In HALTED: halt=1, all other outputs 0. opcode and zero are ignored. Only rst exits.
  - HALT_STICKY=0: halt is high for phase 4 only, and sequencing continues normally.
- Opcode is sampled only in phases 4-7. Opcode changes in phases 0-3 have no effect on outputs.
- zero is sampled only in phase 6.
- Illegal/unreachable state encodings go to INST_ADDR on the next edge, with all outputs 0 while in them.
- wr and data_e are never high at the same time as rd.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined: adds input step (1 bit) and output waiting (1 bit).
  - The transition STORE(7) -> INST_ADDR(0) occurs only on a cycle where step=1. Otherwise the controller holds in phase 7, with waiting=1 and all other outputs 0.
  - wr and ld_ac assert only on the first cycle spent in phase 7.
  - rst overrides step. waiting resets to 0.
  - The first instruction after reset runs without a step pulse.
- When undefined: no step or waiting ports; free-running 8-cycle sequencing as above.

Test Plan:
- Reset then free run, opcode=ADD(2), zero=0 -> phases 0..7 in order. ld_ir high in cycles 2-3; rd high in cycles 1-3 and 5-7; ld_ac high only in cycle 7; phase returns to 0 on cycle 8.
- opcode=SKZ(1): zero=1 -> inc_pc high in phases 4 and 6. zero=0 -> inc_pc high in phase 4 only. rd stays 0 in phases 5-7.
- opcode=STO(6) -> data_e high in phases 6-7, wr high in phase 7 only, rd=0 in phases 5-7. opcode=JMP(7) -> ld_pc high in phases 6-7.
- HALT_STICKY=1, opcode=HLT(0) -> halt=1 from phase 4 onward and held for 20+ cycles with all other outputs 0. Asserting rst=1 for one edge -> phase=0, sel=1, halt=0.
- HALT_STICKY=0, opcode=HLT(0) -> halt high for exactly one cycle (phase 4); sequencing continues to phase 5.
- rst=1 asserted in phase 6 with opcode=STO -> next cycle phase=0, wr=0, data_e=0. With SEQ_SINGLE_STEP_EN: step held 0 -> held at phase 7 with waiting=1 and wr pulsed once only; step=1 -> phase 0 next cycle.
